// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: runtime-loaded 1..PAT_LEN bit pattern,
// valid-qualified input, overlap/non-overlap mode and saturating match counter.
module seq_detect_prog #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(PAT_LEN + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cfg_load,
   input  logic [PAT_LEN-1:0] i_pattern,
   input  logic [LEN_W-1:0]   i_len,
   input  logic               i_overlap,
   input  logic               i_valid,
   input  logic               i_seq,
   input  logic               i_cnt_clr,
   output logic               o_match,
   output logic [CNT_W-1:0]   o_count
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PAT_LEN-1:0] pattern_q;
   logic [PAT_LEN-1:0] hist_q;
   logic [PAT_LEN-1:0] hist_next;
   logic [PAT_LEN-1:0] bit_ok;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   fill_inc;
   logic [LEN_W-1:0]   len_eff;
   logic               overlap_q;
   logic               accept;
   logic               hit;

   // A load cycle owns the datapath, so a bit presented with it is discarded.
   assign accept    = i_valid & ~i_cfg_load;
   assign hist_next = {hist_q[PAT_LEN-2:0], i_seq};
   assign fill_inc  = (fill_q == LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
   assign len_eff   = (i_len == '0 || i_len > LEN_MAX) ? LEN_MAX : i_len;

   // Positions at or above the active length always compare true.
   for (genvar b = 0; b < PAT_LEN; b++) begin : g_cmp
      assign bit_ok[b] = (LEN_W'(b) >= len_q) | (hist_next[b] == pattern_q[b]);
   end

   assign hit = accept & (fill_inc >= len_q) & (&bit_ok);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pattern_q <= '0;
         len_q     <= LEN_MAX;
         overlap_q <= 1'b1;
         hist_q    <= '0;
         fill_q    <= '0;
         o_match   <= 1'b0;
      end else begin
         o_match <= hit;
         if (i_cfg_load) begin
            pattern_q <= i_pattern;
            len_q     <= len_eff;
            overlap_q <= i_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
         end else if (accept) begin
            hist_q <= hist_next;
            fill_q <= (hit & ~overlap_q) ? '0 : fill_inc;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_count <= '0;
      else if (i_cnt_clr)
         o_count <= hit ? CNT_W'(1) : '0;
      else if (hit && o_count != CNT_MAX)
         o_count <= o_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus random traffic against a
// queue-based model of the detection rules.
module tb_seq_detect_prog;
   localparam int PAT_LEN = 4;
   localparam int CNT_W   = 2;
   localparam int LEN_W   = $clog2(PAT_LEN + 1);

   logic               clk = 1'b0;
   logic               rst, cfg_load, overlap, valid, seq, cnt_clr;
   logic [PAT_LEN-1:0] pattern;
   logic [LEN_W-1:0]   len;
   logic               match;
   logic [CNT_W-1:0]   count;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit                 m_bits[$];
   int                 m_since;
   int                 m_len;
   logic [PAT_LEN-1:0] m_pat;
   bit                 m_ov;
   bit                 exp_match;
   int                 exp_count;

   always #5 clk = ~clk;

   seq_detect_prog #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_cfg_load(cfg_load), .i_pattern(pattern),
      .i_len(len), .i_overlap(overlap), .i_valid(valid), .i_seq(seq),
      .i_cnt_clr(cnt_clr), .o_match(match), .o_count(count)
   );

   // One clock: model follows the rules on the same inputs, then one-shots drop.
   task automatic tick();
      bit hit;
      hit = 0;
      @(posedge clk);
      if (rst) begin
         m_bits.delete(); m_since = 0; m_pat = '0; m_len = PAT_LEN; m_ov = 1;
         exp_count = 0;
      end else begin
         if (cfg_load) begin
            m_pat = pattern;
            m_len = (len == 0 || int'(len) > PAT_LEN) ? PAT_LEN : int'(len);
            m_ov  = overlap;
            m_bits.delete(); m_since = 0;
         end else if (valid) begin
            m_bits.push_back(seq);
            if (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
            m_since++;
            if (m_since >= m_len) begin
               hit = 1;
               for (int k = 0; k < m_len; k++)
                  if (m_bits[m_bits.size()-1-k] != m_pat[k]) hit = 0;
            end
            if (hit && !m_ov) m_since = 0;
         end
         if (cnt_clr) exp_count = hit ? 1 : 0;
         else if (hit && exp_count < (1 << CNT_W) - 1) exp_count++;
      end
      exp_match = hit;
      #1;
      rst = 0; cfg_load = 0; cnt_clr = 0; valid = 0;
   endtask

   task automatic load(input logic [PAT_LEN-1:0] p, input int l, input bit ov);
      pattern = p; len = LEN_W'(l); overlap = ov; cfg_load = 1; valid = 0;
      tick();
   endtask

   task automatic clear_cnt();
      cnt_clr = 1; valid = 0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1;
      tick();
      if (match !== 1'b0 || count !== '0) begin
         errors++;
         $display("FAIL reset: match=%b count=%0d expected match=0 count=0", match, count);
      end
      checks++;
      valid = 1; seq = 0;
      tick();
      if (match !== 1'b0) begin
         errors++;
         $display("FAIL reset_zero_pat_partial: match=%b expected 0", match);
      end
      checks++;
   endtask

   task automatic test_overlap();
      logic [4:0] s;
      int pulses;
      s = 5'b10101; pulses = 0;
      load(4'b0101, 3, 1);
      clear_cnt();
      for (int i = 4; i >= 0; i--) begin
         valid = 1; seq = s[i];
         tick();
         pulses += int'(match);
         if (match !== exp_match || count !== CNT_W'(exp_count)) begin
            errors++;
            $display("FAIL overlap bit%0d: match=%b count=%0d expected match=%b count=%0d",
                     5 - i, match, count, exp_match, exp_count);
         end
         checks++;
      end
      if (count !== 2'd2 || pulses != 2) begin
         errors++;
         $display("FAIL overlap_total: count=%0d pulses=%0d expected 2/2", count, pulses);
      end
      checks++;
   endtask

   task automatic test_nonoverlap();
      logic [6:0] s;
      s = 7'b1011011;
      for (int ov = 0; ov < 2; ov++) begin
         load(4'b1011, 4, ov[0]);
         clear_cnt();
         for (int i = 6; i >= 0; i--) begin
            valid = 1; seq = s[i];
            tick();
            if (match !== exp_match || count !== CNT_W'(exp_count)) begin
               errors++;
               $display("FAIL nonoverlap ov=%0d bit%0d: match=%b count=%0d expected match=%b count=%0d",
                        ov, 7 - i, match, count, exp_match, exp_count);
            end
            checks++;
         end
         if (count !== CNT_W'(ov + 1)) begin
            errors++;
            $display("FAIL nonoverlap_total ov=%0d: count=%0d expected %0d", ov, count, ov + 1);
         end
         checks++;
      end
   endtask

   task automatic test_valid_gaps();
      logic [4:0] s;
      s = 5'b10101;
      load(4'b0101, 3, 1);
      clear_cnt();
      for (int i = 4; i >= 0; i--) begin
         valid = 1; seq = s[i];
         tick();
         for (int g = 0; g < 4; g++) begin
            if (match !== exp_match || count !== CNT_W'(exp_count)) begin
               errors++;
               $display("FAIL gaps bit%0d cyc%0d: match=%b count=%0d expected match=%b count=%0d",
                        5 - i, g, match, count, exp_match, exp_count);
            end
            checks++;
            if (g < 3) begin
               valid = 0; seq = $urandom_range(0, 1);
               tick();
            end
         end
      end
      if (count !== 2'd2) begin
         errors++;
         $display("FAIL gaps_total: count=%0d expected 2", count);
      end
      checks++;
   endtask

   task automatic test_saturation();
      load(4'b0101, 3, 1);
      clear_cnt();
      valid = 1; seq = 1;
      tick();
      for (int n = 0; n < 5; n++) begin
         valid = 1; seq = 0; tick();
         valid = 1; seq = 1; tick();
      end
      if (count !== 2'd3 || count !== CNT_W'(exp_count)) begin
         errors++;
         $display("FAIL saturate: count=%0d expected 3", count);
      end
      checks++;
      clear_cnt();
      if (count !== 2'd0) begin
         errors++;
         $display("FAIL clr_alone: count=%0d expected 0", count);
      end
      checks++;
      valid = 1; seq = 0; tick();
      valid = 1; seq = 1; cnt_clr = 1; tick();
      if (match !== 1'b1 || count !== 2'd1) begin
         errors++;
         $display("FAIL clr_with_match: match=%b count=%0d expected match=1 count=1", match, count);
      end
      checks++;
   endtask

   task automatic test_len_clamp();
      logic [3:0] s;
      logic [3:0] f;
      s = 4'b1011; f = 4'b1011;
      load(4'b1011, 0, 1);
      clear_cnt();
      for (int i = 3; i >= 0; i--) begin
         valid = 1; seq = s[i];
         tick();
         if (match !== exp_match || match !== (i == 0)) begin
            errors++;
            $display("FAIL len0 bit%0d: match=%b expected %b", 4 - i, match, exp_match);
         end
         checks++;
      end
      // partial 1,0 then load with a valid bit; the stale prefix must not complete
      valid = 1; seq = 1; tick();
      valid = 1; seq = 0; tick();
      pattern = 4'b1011; len = LEN_W'(4); overlap = 1; cfg_load = 1; valid = 1; seq = 1;
      tick();
      for (int i = 3; i >= 0; i--) begin
         valid = 1; seq = f[i];
         tick();
         if (match !== exp_match || match !== (i == 0)) begin
            errors++;
            $display("FAIL load_mid bit%0d: match=%b expected %b", 4 - i, match, exp_match);
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] s;
      s = 3'b101;
      load(4'b0101, 3, 1);
      clear_cnt();
      valid = 1; seq = 1; tick();
      valid = 1; seq = 0; tick();
      rst = 1; tick();
      if (match !== 1'b0 || count !== '0) begin
         errors++;
         $display("FAIL rst_mid: match=%b count=%0d expected 0/0", match, count);
      end
      checks++;
      load(4'b0101, 3, 1);
      for (int i = 2; i >= 0; i--) begin
         valid = 1; seq = s[i];
         tick();
         if (match !== exp_match || match !== (i == 0)) begin
            errors++;
            $display("FAIL rst_mid_reseen bit%0d: match=%b expected %b", 3 - i, match, exp_match);
         end
         checks++;
      end
      // default config after reset is 0000/len4: zeros straddling reset must not count
      valid = 1; seq = 0; tick();
      valid = 1; seq = 0; tick();
      rst = 1; tick();
      for (int i = 0; i < 4; i++) begin
         valid = 1; seq = 0;
         tick();
         if (match !== exp_match || match !== (i == 3)) begin
            errors++;
            $display("FAIL rst_straddle bit%0d: match=%b expected %b", i + 1, match, exp_match);
         end
         checks++;
      end
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 1500; c++) begin
         r = $urandom_range(0, 99);
         if (r < 2) rst = 1;
         else if (r < 7) begin
            cfg_load = 1;
            pattern  = PAT_LEN'($urandom);
            len      = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
            overlap  = $urandom_range(0, 1);
         end
         valid   = ($urandom_range(0, 99) < 75);
         seq     = $urandom_range(0, 1);
         cnt_clr = ($urandom_range(0, 24) == 0);
         tick();
         if (match !== exp_match || count !== CNT_W'(exp_count)) begin
            errors++;
            $display("FAIL random cyc%0d: match=%b count=%0d expected match=%b count=%0d",
                     c, match, count, exp_match, exp_count);
         end
         checks++;
      end
   endtask

   initial begin
      rst = 0; cfg_load = 0; overlap = 1; valid = 0; seq = 0; cnt_clr = 0;
      pattern = '0; len = '0;
      m_since = 0; m_len = PAT_LEN; m_pat = '0; m_ov = 1; exp_match = 0; exp_count = 0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_valid_gaps();
      test_saturation();
      test_len_clamp();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
